// File: rtl/mem_wb_stage.sv
// MEM/WB stage: buffers up to two selected results and drains them to the
// register file as one (word) or two (double) write beats.
module mem_wb_stage #(
  parameter int REG_W  = 32,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       mem_result,
  input  logic [63:0]       alu_result,
  input  logic [DEST_W-1:0] dest,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              is_double,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_W-1:0]  wb_data,
  output logic [DEST_W-1:0] wb_dest,
  output logic              wb_we,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  typedef struct packed {
    logic [63:0]       data;
    logic [DEST_W-1:0] dest;
    logic              dbl;
  } entry_t;

  state_t             state_r;
  state_t             state_next_s;
  entry_t             mem_r [2];
  logic [1:0]         count_r;
  logic [1:0]         count_next_s;
  logic [1:0]         count_after_pop_s;
  logic               wr_ptr_r;
  logic               rd_ptr_r;
  logic               rd_ptr_next_s;
  entry_t             head_s;
  entry_t             head_next_s;
  entry_t             new_entry_s;
  logic               push_s;
  logic               pop_s;
  logic               hs_s;
  logic               wb_valid_r;
  logic               wb_valid_next_s;
  logic [REG_W-1:0]   wb_data_r;
  logic [REG_W-1:0]   wb_data_next_s;
  logic [DEST_W-1:0]  wb_dest_r;
  logic [DEST_W-1:0]  wb_dest_next_s;
  logic               wb_we_r;
  logic               wb_we_next_s;
  logic               busy_r;
  logic               busy_next_s;
  logic               in_ready_r;
  logic               in_ready_next_s;

  assign head_s = mem_r[rd_ptr_r];
  assign hs_s   = wb_valid_r && wb_ready;
  // Only beats that finish an entry release it; BEAT0 of a double keeps it.
  assign pop_s  = hs_s && (((state_r == BEAT0) && !head_s.dbl) || (state_r == BEAT1));
  assign push_s = in_valid && in_ready_r && !flush && reg_write;

  // Next-state, FIFO bookkeeping and next output values for the registered outputs.
  always_comb begin
    new_entry_s.data  = mem_to_reg ? mem_result : alu_result;
    new_entry_s.dest  = dest;
    new_entry_s.dbl   = is_double;
    count_after_pop_s = count_r - {1'b0, pop_s};
    count_next_s      = count_after_pop_s + {1'b0, push_s};
    rd_ptr_next_s     = rd_ptr_r ^ pop_s;
    state_next_s      = state_r;

    case (state_r)
      IDLE: begin
        if (count_next_s != 2'd0) state_next_s = BEAT0;
        else                      state_next_s = IDLE;
      end
      BEAT0: begin
        if (hs_s) begin
          if (head_s.dbl)                state_next_s = BEAT1;
          else if (count_next_s != 2'd0) state_next_s = BEAT0;
          else                           state_next_s = IDLE;
        end else begin
          state_next_s = BEAT0;
        end
      end
      BEAT1: begin
        if (hs_s) begin
          if (count_next_s != 2'd0) state_next_s = BEAT0;
          else                      state_next_s = IDLE;
        end else begin
          state_next_s = BEAT1;
        end
      end
      default: state_next_s = IDLE;
    endcase

    if (flush) begin
      count_next_s = 2'd0;
      state_next_s = IDLE;
    end else begin
      count_next_s = count_next_s;
    end

    // A push into an otherwise-empty FIFO becomes the head immediately.
    if (push_s && (count_after_pop_s == 2'd0)) head_next_s = new_entry_s;
    else                                       head_next_s = mem_r[rd_ptr_next_s];

    case (state_next_s)
      BEAT0: begin
        wb_data_next_s = REG_W'(head_next_s.data[31:0]);
        wb_dest_next_s = head_next_s.dest;
      end
      BEAT1: begin
        wb_data_next_s = REG_W'(head_next_s.data[63:32]);
        wb_dest_next_s = head_next_s.dest + DEST_W'(1);
      end
      default: begin
        wb_data_next_s = '0;
        wb_dest_next_s = '0;
      end
    endcase

    wb_valid_next_s = (state_next_s != IDLE);
    wb_we_next_s    = wb_valid_next_s && (wb_dest_next_s != '0);
    busy_next_s     = (count_next_s != 2'd0) || (state_next_s != IDLE);
    in_ready_next_s = (count_next_s < 2'd2);
  end

  // State, FIFO storage/pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      count_r    <= 2'd0;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      mem_r[0]   <= '0;
      mem_r[1]   <= '0;
      wb_valid_r <= 1'b0;
      wb_data_r  <= '0;
      wb_dest_r  <= '0;
      wb_we_r    <= 1'b0;
      busy_r     <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      count_r    <= count_next_s;
      wb_valid_r <= wb_valid_next_s;
      wb_data_r  <= wb_data_next_s;
      wb_dest_r  <= wb_dest_next_s;
      wb_we_r    <= wb_we_next_s;
      busy_r     <= busy_next_s;
      in_ready_r <= in_ready_next_s;
      if (flush) begin
        wr_ptr_r <= 1'b0;
        rd_ptr_r <= 1'b0;
      end else begin
        rd_ptr_r <= rd_ptr_next_s;
        if (push_s) begin
          mem_r[wr_ptr_r] <= new_entry_s;
          wr_ptr_r        <= ~wr_ptr_r;
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
      end
    end
  end

  assign in_ready = in_ready_r;
  assign wb_valid = wb_valid_r;
  assign wb_data  = wb_data_r;
  assign wb_dest  = wb_dest_r;
  assign wb_we    = wb_we_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed, table-driven bench for mem_wb_stage plus hand-written flush and
// asynchronous-reset sequences.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] mem_result;
  logic [63:0] alu_result;
  logic [4:0]  dest;
  logic        reg_write;
  logic        mem_to_reg;
  logic        is_double;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        wb_we;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_stage #(.REG_W(32), .DEST_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mem_result(mem_result), .alu_result(alu_result), .dest(dest),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .is_double(is_double),
    .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_dest(wb_dest), .wb_we(wb_we), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        m2r;
    logic        rw;
    logic        dbl;
    logic        rdy;
    logic [63:0] mem;
    logic [63:0] alu;
    logic [4:0]  dst;
    logic        e_ir;
    logic        e_v;
    logic [31:0] e_data;
    logic [4:0]  e_dest;
    logic        e_we;
    logic        e_busy;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(logic iv, logic m2r, logic rw, logic dbl, logic rdy,
                              logic [63:0] mem, logic [63:0] alu, logic [4:0] dst,
                              logic e_ir, logic e_v, logic [31:0] e_data,
                              logic [4:0] e_dest, logic e_we, logic e_busy);
    vec_t v;
    v.iv = iv; v.m2r = m2r; v.rw = rw; v.dbl = dbl; v.rdy = rdy;
    v.mem = mem; v.alu = alu; v.dst = dst;
    v.e_ir = e_ir; v.e_v = e_v; v.e_data = e_data; v.e_dest = e_dest;
    v.e_we = e_we; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_ir, input logic e_v,
                         input logic [31:0] e_data, input logic [4:0] e_dest,
                         input logic e_we, input logic e_busy);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(e_ir));
    chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(e_v));
    chk({tag, ".wb_data"},  64'(wb_data),  64'(e_data));
    chk({tag, ".wb_dest"},  64'(wb_dest),  64'(e_dest));
    chk({tag, ".wb_we"},    64'(wb_we),    64'(e_we));
    chk({tag, ".busy"},     64'(busy),     64'(e_busy));
  endtask

  task automatic drive(input logic iv, input logic m2r, input logic rw, input logic dbl,
                       input logic rdy, input logic fl, input logic [63:0] mem,
                       input logic [63:0] alu, input logic [4:0] dst);
    in_valid = iv; mem_to_reg = m2r; reg_write = rw; is_double = dbl;
    wb_ready = rdy; flush = fl; mem_result = mem; alu_result = alu; dest = dst;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // word load, double across dest wrap, dropped reg_write=0, backpressure, dest 0, back-to-back
    vecs[0]  = mk(1, 1, 1, 0, 1, 64'h10, 64'hDEAD, 5'd3,  1, 1, 32'h10, 5'd3, 1, 1);
    vecs[1]  = mk(0, 0, 0, 0, 1, 64'h0, 64'h0, 5'd0,      1, 0, 32'h0, 5'd0, 0, 0);
    vecs[2]  = mk(1, 0, 1, 1, 1, 64'h0, 64'h1111_2222_3333_4444, 5'd31,
                  1, 1, 32'h3333_4444, 5'd31, 1, 1);
    vecs[3]  = mk(0, 0, 0, 0, 1, 64'h0, 64'h0, 5'd0,      1, 1, 32'h1111_2222, 5'd0, 0, 1);
    vecs[4]  = mk(0, 0, 0, 0, 1, 64'h0, 64'h0, 5'd0,      1, 0, 32'h0, 5'd0, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 1, 64'h0, 64'h5, 5'd7,      1, 0, 32'h0, 5'd0, 0, 0);
    vecs[6]  = mk(1, 0, 1, 0, 0, 64'h0, 64'hA, 5'd1,      1, 1, 32'hA, 5'd1, 1, 1);
    vecs[7]  = mk(1, 0, 1, 0, 0, 64'h0, 64'hB, 5'd2,      0, 1, 32'hA, 5'd1, 1, 1);
    vecs[8]  = mk(1, 0, 1, 0, 0, 64'h0, 64'hC, 5'd4,      0, 1, 32'hA, 5'd1, 1, 1);
    vecs[9]  = mk(1, 0, 1, 0, 1, 64'h0, 64'hC, 5'd4,      1, 1, 32'hB, 5'd2, 1, 1);
    vecs[10] = mk(0, 0, 0, 0, 1, 64'h0, 64'h0, 5'd0,      1, 0, 32'h0, 5'd0, 0, 0);
    vecs[11] = mk(1, 0, 1, 0, 0, 64'h0, 64'h55, 5'd0,     1, 1, 32'h55, 5'd0, 0, 1);
    vecs[12] = mk(0, 0, 0, 0, 1, 64'h0, 64'h0, 5'd0,      1, 0, 32'h0, 5'd0, 0, 0);
    vecs[13] = mk(1, 0, 1, 0, 1, 64'h0, 64'h77, 5'd9,     1, 1, 32'h77, 5'd9, 1, 1);
    vecs[14] = mk(1, 1, 1, 0, 1, 64'h88, 64'h0, 5'd10,    1, 1, 32'h88, 5'd10, 1, 1);
    vecs[15] = mk(0, 0, 0, 0, 1, 64'h0, 64'h0, 5'd0,      1, 0, 32'h0, 5'd0, 0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
    step();
    step();
    chk_out("reset", 1, 0, 32'h0, 5'd0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].iv, vecs[i].m2r, vecs[i].rw, vecs[i].dbl, vecs[i].rdy, 1'b0,
            vecs[i].mem, vecs[i].alu, vecs[i].dst);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_v, vecs[i].e_data,
              vecs[i].e_dest, vecs[i].e_we, vecs[i].e_busy);
    end

    // flush during BEAT1 with a second entry queued
    drive(1, 0, 1, 1, 0, 0, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 5'd5);
    step();
    chk_out("fl_b0", 1, 1, 32'hCCCC_DDDD, 5'd5, 1, 1);
    drive(1, 0, 1, 0, 1, 0, 64'h0, 64'h99, 5'd6);
    step();
    chk_out("fl_b1", 0, 1, 32'hAAAA_BBBB, 5'd6, 1, 1);
    drive(1, 0, 1, 0, 1, 1, 64'h0, 64'h42, 5'd8);
    step();
    chk_out("fl_edge", 1, 0, 32'h0, 5'd0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 64'h0, 64'h0, 5'd0);
    step();
    chk_out("fl_after", 1, 0, 32'h0, 5'd0, 0, 0);

    // flush while in_ready=1: the same-edge offer must not be captured
    drive(1, 0, 1, 0, 0, 0, 64'h0, 64'h31, 5'd3);
    step();
    chk_out("fl2_pre", 1, 1, 32'h31, 5'd3, 1, 1);
    drive(1, 0, 1, 0, 0, 1, 64'h0, 64'h41, 5'd4);
    step();
    chk_out("fl2_edge", 1, 0, 32'h0, 5'd0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 64'h0, 64'h0, 5'd0);
    step();
    chk_out("fl2_after", 1, 0, 32'h0, 5'd0, 0, 0);

    // asynchronous reset pulse while a double sits in BEAT0
    drive(1, 0, 1, 1, 0, 0, 64'h0, 64'h1234_5678_9ABC_DEF0, 5'd12);
    step();
    chk_out("rst_b0", 1, 1, 32'h9ABC_DEF0, 5'd12, 1, 1);
    drive(0, 0, 0, 0, 1, 0, 64'h0, 64'h0, 5'd0);
    #2 rst_n = 1'b0;
    #1 chk_out("rst_async", 1, 0, 32'h0, 5'd0, 0, 0);
    #2 rst_n = 1'b1;
    step();
    chk_out("rst_rel1", 1, 0, 32'h0, 5'd0, 0, 0);
    step();
    chk_out("rst_rel2", 1, 0, 32'h0, 5'd0, 0, 0);
    drive(1, 0, 1, 0, 1, 0, 64'h0, 64'h3, 5'd2);
    step();
    chk_out("rst_resume", 1, 1, 32'h3, 5'd2, 1, 1);
    drive(0, 0, 0, 0, 1, 0, 64'h0, 64'h0, 5'd0);
    step();
    chk_out("rst_idle", 1, 0, 32'h0, 5'd0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
